blob_tracker: RTL and testbench
===============================

BLOB_TRACKER -- requirements
Module: blob_tracker

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-003 SHALL have parameter MIN_COUNT, default 64, minimum white-pixel count for a valid blob.
REQ-004 SHALL have port iClk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port iRst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port iPixel, input, 8, binarised pixel from the threshold stage; white when iPixel[7]=1.
REQ-007 SHALL have port iValid, input, 1, iPixel/iX_Cont/iY_Cont qualify this cycle.
REQ-008 SHALL have ports iX_Cont and iY_Cont, input, 16 each, coordinates of the current pixel.
REQ-009 SHALL have ports oX_Min, oX_Max, oY_Min, oY_Max, output, 16 each, bounding box of the last completed frame.
REQ-010 SHALL have ports oCent_X and oCent_Y, output, 16 each, centroid of the last completed frame.
REQ-011 SHALL have port oCount, output, 20, white-pixel count of the last completed frame.
REQ-012 SHALL have port oFound, output, 1, high when oCount >= MIN_COUNT.
REQ-013 SHALL have port oFrame_Done, output, 1, one-cycle pulse when results update.

Function
REQ-014 Active pixel: iValid=1, iX_Cont<H_ACTIVE and iY_Cont<V_ACTIVE; all other cycles SHALL be ignored.
REQ-015 Frame start is the active pixel (0,0); it SHALL reset the accumulators before including that pixel: count=0, X_min=Y_min=0xFFFF, X_max=Y_max=0, sums=0.
REQ-016 Each white active pixel SHALL increment count (20 b), add X to sum_x (28 b) and Y to sum_y (28 b), and update min/max; a pixel at (0,0) counts.
REQ-017 Frame end is the active pixel (H_ACTIVE-1, V_ACTIVE-1); its own contribution SHALL be included in the snapshot.
REQ-018 The FSM SHALL have states IDLE, SNAP, DIV_X, DIV_Y and PUBLISH.
REQ-019 On frame end in IDLE, the FSM SHALL go to SNAP (1 cycle, latch count/sums/box), then DIV_X (28 cycles), then DIV_Y (28 cycles), then PUBLISH (1 cycle), then IDLE.
REQ-020 Division SHALL be restoring, 1 quotient bit per cycle, with the quotient truncated to 16 bits (floor).
REQ-021 oFrame_Done SHALL assert in PUBLISH, exactly 58 cycles after the edge that samples the frame-end pixel, and all result outputs SHALL change on that same edge.
REQ-022 If the snapped count < MIN_COUNT (including 0): oFound=0, all box/centroid outputs = 0, oCount = the snapped value, and the divider result SHALL be discarded (no divide-by-zero effect); latency is unchanged.
REQ-023 Accumulation of the next frame SHALL proceed concurrently with DIV_X/DIV_Y from the snapshot.
REQ-024 A frame end arriving while not in IDLE SHALL be dropped, and prior outputs SHALL remain unchanged.
REQ-025 Between PUBLISH events, all result outputs SHALL hold.
REQ-026 A frame with no frame-start pixel SHALL continue accumulating into the previous frame's values.

Reset
REQ-027 iRst_n low SHALL asynchronously force: all outputs 0, FSM to IDLE, accumulators to their frame-start values, and the divider cleared.
REQ-028 Reset mid-division SHALL abort the division, and no oFrame_Done pulse SHALL follow.
REQ-029 Reset release SHALL be honoured synchronously to iClk; the first frame after reset SHALL begin at the next (0,0) pixel.

Configuration
REQ-030 Macro BLOB_TRACKER_OVERLAY_EN, when defined, SHALL add outputs oPixel (8) and oValid (1).
REQ-031 With BLOB_TRACKER_OVERLAY_EN defined, oPixel/oValid SHALL be iPixel/iValid delayed by 1 cycle, with oPixel=128 where the pixel lies on the published box perimeter while oFound=1.
REQ-032 Without BLOB_TRACKER_OVERLAY_EN, these ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-033 Single white 8x8 square at X 100..107, Y 50..57 -> box 100/107/50/57, oCount=64, oFound=1, centroid (103,53), oFrame_Done 58 cycles after the frame end.
REQ-034 All-black frame -> oCount=0, oFound=0, all box/centroid outputs 0, oFrame_Done still pulses at 58 cycles.
REQ-035 Only pixels (0,0) and (639,479) white, MIN_COUNT=2 -> box 0/639/0/479, centroid (319,239), oCount=2.
REQ-036 Frame end injected 10 cycles after a previous frame end -> the second frame end is dropped, there is exactly one oFrame_Done, and the outputs match the first frame.
REQ-037 iRst_n pulsed low during DIV_Y -> outputs 0 immediately, no oFrame_Done, and the next full frame reports correctly.
REQ-038 With BLOB_TRACKER_OVERLAY_EN defined, the frame after REQ-033 -> oPixel=128 at (100,50) and (107,57), and oPixel=iPixel delayed by 1 cycle elsewhere.

Source files
------------

// File: rtl/blob_tracker.sv
// Bright-blob tracker: per-frame white-pixel count, bounding box and centroid (restoring divide).
// Define BLOB_TRACKER_OVERLAY_EN to add the oPixel/oValid box-overlay video outputs.
module blob_tracker #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int MIN_COUNT = 64
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic [7:0]  iPixel,
  input  logic        iValid,
  input  logic [15:0] iX_Cont,
  input  logic [15:0] iY_Cont,
  output logic [15:0] oX_Min,
  output logic [15:0] oX_Max,
  output logic [15:0] oY_Min,
  output logic [15:0] oY_Max,
  output logic [15:0] oCent_X,
  output logic [15:0] oCent_Y,
  output logic [19:0] oCount,
  output logic        oFound,
  output logic        oFrame_Done
`ifdef BLOB_TRACKER_OVERLAY_EN
  ,
  output logic [7:0]  oPixel,
  output logic        oValid
`endif
);
  localparam logic [15:0] H_LIM     = 16'(H_ACTIVE);
  localparam logic [15:0] V_LIM     = 16'(V_ACTIVE);
  localparam logic [15:0] H_LAST    = 16'(H_ACTIVE - 1);
  localparam logic [15:0] V_LAST    = 16'(V_ACTIVE - 1);
  localparam logic [19:0] MIN_CNT   = 20'(MIN_COUNT);
  localparam logic [4:0]  LAST_STEP = 5'd27;

  typedef enum logic [2:0] {IDLE, SNAP, DIV_X, DIV_Y, PUBLISH} state_t;
  state_t state_q;

  logic pix_active, frame_start, frame_end, white;
  assign pix_active  = iValid && (iX_Cont < H_LIM) && (iY_Cont < V_LIM);
  assign frame_start = pix_active && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign frame_end   = pix_active && (iX_Cont == H_LAST) && (iY_Cont == V_LAST);
  assign white       = pix_active && iPixel[7];

  logic [19:0] cnt_q, cnt_d;
  logic [27:0] sx_q, sx_d, sy_q, sy_d;
  logic [15:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;

  // Frame start clears first, so the (0,0) pixel itself is still counted.
  always_comb begin
    cnt_d  = cnt_q;
    sx_d   = sx_q;
    sy_d   = sy_q;
    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    if (frame_start) begin
      cnt_d  = '0;
      sx_d   = '0;
      sy_d   = '0;
      xmin_d = 16'hFFFF;
      ymin_d = 16'hFFFF;
      xmax_d = '0;
      ymax_d = '0;
    end
    if (white) begin
      cnt_d = cnt_d + 20'd1;
      sx_d  = sx_d + {12'd0, iX_Cont};
      sy_d  = sy_d + {12'd0, iY_Cont};
      if (iX_Cont < xmin_d) xmin_d = iX_Cont;
      if (iX_Cont > xmax_d) xmax_d = iX_Cont;
      if (iY_Cont < ymin_d) ymin_d = iY_Cont;
      if (iY_Cont > ymax_d) ymax_d = iY_Cont;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q  <= '0;
      sx_q   <= '0;
      sy_q   <= '0;
      xmin_q <= 16'hFFFF;
      ymin_q <= 16'hFFFF;
      xmax_q <= '0;
      ymax_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      sx_q   <= sx_d;
      sy_q   <= sy_d;
      xmin_q <= xmin_d;
      xmax_q <= xmax_d;
      ymin_q <= ymin_d;
      ymax_q <= ymax_d;
    end
  end

  // Restoring divider: dq_q shifts the dividend out and the quotient in.
  logic [19:0] snap_cnt_q, rem_q, rem_nx, diff;
  logic [27:0] snap_sy_q, dq_q, dq_nx;
  logic [15:0] snap_xmin_q, snap_xmax_q, snap_ymin_q, snap_ymax_q, quot_x_q;
  logic [4:0]  step_q;
  logic [20:0] rem_sh;
  logic        q_bit;

  assign rem_sh = {rem_q, dq_q[27]};
  assign q_bit  = rem_sh >= {1'b0, snap_cnt_q};
  assign diff   = rem_sh[19:0] - snap_cnt_q;
  assign rem_nx = q_bit ? diff : rem_sh[19:0];
  assign dq_nx  = {dq_q[26:0], q_bit};

  logic [15:0] x_min_q, x_max_q, y_min_q, y_max_q, cent_x_q, cent_y_q;
  logic [19:0] count_q;
  logic        found_q, done_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q     <= IDLE;
      snap_cnt_q  <= '0;
      snap_sy_q   <= '0;
      snap_xmin_q <= '0;
      snap_xmax_q <= '0;
      snap_ymin_q <= '0;
      snap_ymax_q <= '0;
      dq_q        <= '0;
      rem_q       <= '0;
      step_q      <= '0;
      quot_x_q    <= '0;
      x_min_q     <= '0;
      x_max_q     <= '0;
      y_min_q     <= '0;
      y_max_q     <= '0;
      cent_x_q    <= '0;
      cent_y_q    <= '0;
      count_q     <= '0;
      found_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (frame_end) state_q <= SNAP;
        SNAP: begin
          snap_cnt_q  <= cnt_q;
          snap_sy_q   <= sy_q;
          snap_xmin_q <= xmin_q;
          snap_xmax_q <= xmax_q;
          snap_ymin_q <= ymin_q;
          snap_ymax_q <= ymax_q;
          dq_q        <= sx_q;
          rem_q       <= '0;
          step_q      <= '0;
          state_q     <= DIV_X;
        end
        DIV_X: begin
          dq_q   <= dq_nx;
          rem_q  <= rem_nx;
          step_q <= step_q + 5'd1;
          if (step_q == LAST_STEP) begin
            quot_x_q <= dq_nx[15:0];
            dq_q     <= snap_sy_q;
            rem_q    <= '0;
            step_q   <= '0;
            state_q  <= DIV_Y;
          end
        end
        DIV_Y: begin
          dq_q   <= dq_nx;
          rem_q  <= rem_nx;
          step_q <= step_q + 5'd1;
          if (step_q == LAST_STEP) state_q <= PUBLISH;
        end
        PUBLISH: begin
          done_q  <= 1'b1;
          count_q <= snap_cnt_q;
          // Too few pixels: geometry (and any divide-by-zero quotient) is discarded.
          if (snap_cnt_q >= MIN_CNT) begin
            found_q  <= 1'b1;
            x_min_q  <= snap_xmin_q;
            x_max_q  <= snap_xmax_q;
            y_min_q  <= snap_ymin_q;
            y_max_q  <= snap_ymax_q;
            cent_x_q <= quot_x_q;
            cent_y_q <= dq_q[15:0];
          end else begin
            found_q  <= 1'b0;
            x_min_q  <= '0;
            x_max_q  <= '0;
            y_min_q  <= '0;
            y_max_q  <= '0;
            cent_x_q <= '0;
            cent_y_q <= '0;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign oX_Min      = x_min_q;
  assign oX_Max      = x_max_q;
  assign oY_Min      = y_min_q;
  assign oY_Max      = y_max_q;
  assign oCent_X     = cent_x_q;
  assign oCent_Y     = cent_y_q;
  assign oCount      = count_q;
  assign oFound      = found_q;
  assign oFrame_Done = done_q;

`ifdef BLOB_TRACKER_OVERLAY_EN
  logic       in_x, in_y, on_perim, ovl_val_q;
  logic [7:0] ovl_pix_q;
  assign in_x     = (iX_Cont >= x_min_q) && (iX_Cont <= x_max_q);
  assign in_y     = (iY_Cont >= y_min_q) && (iY_Cont <= y_max_q);
  assign on_perim = found_q && ((in_y && ((iX_Cont == x_min_q) || (iX_Cont == x_max_q))) ||
                                (in_x && ((iY_Cont == y_min_q) || (iY_Cont == y_max_q))));
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovl_pix_q <= '0;
      ovl_val_q <= 1'b0;
    end else begin
      ovl_pix_q <= on_perim ? 8'd128 : iPixel;
      ovl_val_q <= iValid;
    end
  end
  assign oPixel = ovl_pix_q;
  assign oValid = ovl_val_q;
`else
  logic pix_unused;
  assign pix_unused = ^iPixel[6:0];
`endif
endmodule

// File: tb/tb_blob_tracker.sv
// Bench for blob_tracker: directed frames plus random sparse frames against a frame-level model.
`timescale 1ns/1ps
module tb_blob_tracker;
  localparam int H = 640;
  localparam int V = 480;
  localparam int MINC = 2;
  localparam int W = 117;

  logic        iClk = 1'b0;
  logic        iRst_n = 1'b0;
  logic [7:0]  iPixel = '0;
  logic        iValid = 1'b0;
  logic [15:0] iX_Cont = '0, iY_Cont = '0;
  logic [15:0] oX_Min, oX_Max, oY_Min, oY_Max, oCent_X, oCent_Y;
  logic [19:0] oCount;
  logic        oFound, oFrame_Done;
`ifdef BLOB_TRACKER_OVERLAY_EN
  logic [7:0]  oPixel;
  logic        oValid;
`endif

  blob_tracker #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_COUNT(MINC)) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iPixel(iPixel), .iValid(iValid),
    .iX_Cont(iX_Cont), .iY_Cont(iY_Cont),
    .oX_Min(oX_Min), .oX_Max(oX_Max), .oY_Min(oY_Min), .oY_Max(oY_Max),
    .oCent_X(oCent_X), .oCent_Y(oCent_Y), .oCount(oCount), .oFound(oFound),
    .oFrame_Done(oFrame_Done)
`ifdef BLOB_TRACKER_OVERLAY_EN
    , .oPixel(oPixel), .oValid(oValid)
`endif
  );

  // Clock
  always #5 iClk = ~iClk;

  logic [W-1:0] dut_vec;
  assign dut_vec = {oCount, oFound, oX_Min, oX_Max, oY_Min, oY_Max, oCent_X, oCent_Y};

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int busy_until = 0;

  // Scoreboard: published results in order, with the cycle each must appear on.
  logic [W-1:0] exp_q[$];
  int           due_q[$];
  logic [W-1:0] cur_exp = '0;

  // Frame-level model of the accumulators.
  int     m_cnt, m_xmin, m_xmax, m_ymin, m_ymax;
  longint m_sx, m_sy;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(int c, bit f, int xmn, int xmx, int ymn, int ymx,
                                        int cx, int cy);
    return {20'(c), f, 16'(xmn), 16'(xmx), 16'(ymn), 16'(ymx), 16'(cx), 16'(cy)};
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_sx = 0; m_sy = 0;
    m_xmin = 65535; m_ymin = 65535; m_xmax = 0; m_ymax = 0;
  endtask

  function automatic logic [W-1:0] model_result();
    if (m_cnt < MINC) return pack(m_cnt, 1'b0, 0, 0, 0, 0, 0, 0);
    return pack(m_cnt, 1'b1, m_xmin, m_xmax, m_ymin, m_ymax,
                int'(m_sx / m_cnt), int'(m_sy / m_cnt));
  endfunction

`ifdef BLOB_TRACKER_OVERLAY_EN
  function automatic bit on_box(logic [W-1:0] r, int x, int y);
    int xmn, xmx, ymn, ymx;
    xmn = int'(r[95:80]); xmx = int'(r[79:64]); ymn = int'(r[63:48]); ymx = int'(r[47:32]);
    if (!r[96]) return 1'b0;
    return ((y >= ymn && y <= ymx) && (x == xmn || x == xmx)) ||
           ((x >= xmn && x <= xmx) && (y == ymn || y == ymx));
  endfunction
`endif

  // Driver: one clock cycle with the given pixel, then model update and output checks.
  task automatic step(input bit v, input int x, input int y, input bit w);
    logic [7:0] pix;
    logic [7:0] exp_pix;
    pix = w ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
    iValid = v; iX_Cont = 16'(x); iY_Cont = 16'(y); iPixel = pix;
    exp_pix = pix;
`ifdef BLOB_TRACKER_OVERLAY_EN
    if (on_box(cur_exp, x, y)) exp_pix = 8'd128;
`endif
    @(posedge iClk);
    cyc++;
    if (v && x < H && y < V) begin
      if (x == 0 && y == 0) model_clear();
      if (w) begin
        m_cnt++; m_sx += x; m_sy += y;
        if (x < m_xmin) m_xmin = x;
        if (x > m_xmax) m_xmax = x;
        if (y < m_ymin) m_ymin = y;
        if (y > m_ymax) m_ymax = y;
      end
      if (x == H - 1 && y == V - 1 && cyc >= busy_until) begin
        exp_q.push_back(model_result());
        due_q.push_back(cyc + 58);
        busy_until = cyc + 59;
      end
    end
    #1;
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("frame_done_hi", W'(oFrame_Done), W'(1));
      cur_exp = exp_q.pop_front();
      void'(due_q.pop_front());
    end else begin
      check("frame_done_lo", W'(oFrame_Done), W'(0));
    end
    check("outputs", dut_vec, cur_exp);
`ifdef BLOB_TRACKER_OVERLAY_EN
    check("ovl_pixel", W'(oPixel), W'(exp_pix));
    check("ovl_valid", W'(oValid), W'(v));
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    #2 iRst_n = 1'b0;
    #1;
    check("rst_outputs", dut_vec, '0);
    check("rst_done", W'(oFrame_Done), W'(0));
    exp_q.delete();
    due_q.delete();
    cur_exp = '0;
    busy_until = 0;
    model_clear();
    iValid = 1'b0;
    repeat (2) begin @(posedge iClk); cyc++; end
    @(negedge iClk);
    iRst_n = 1'b1;
  endtask

  task automatic frame_end(input bit w);
    step(1'b1, H - 1, V - 1, w);
  endtask

  initial begin
    model_clear();
    do_reset();
    idle(3);

    // 8x8 white square
    step(1'b1, 0, 0, 1'b0);
    for (int y = 50; y <= 57; y++)
      for (int x = 100; x <= 107; x++) step(1'b1, x, y, 1'b1);
    frame_end(1'b0);
    idle(60);
    check("sq_count", W'(oCount), W'(64));
    check("sq_found", W'(oFound), W'(1));
    check("sq_box", W'({oX_Min, oX_Max, oY_Min, oY_Max}), W'({16'd100, 16'd107, 16'd50, 16'd57}));
    check("sq_cent", W'({oCent_X, oCent_Y}), W'({16'd103, 16'd53}));

    // Next frame probes overlay corners and an interior pixel
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 100, 50, 1'b0);
    step(1'b1, 107, 57, 1'b1);
    step(1'b1, 103, 53, 1'b1);
    step(1'b1, 120, 53, 1'b0);

    // All-black frame
    step(1'b1, 0, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 10 * i, 3 * i, 1'b0);
    frame_end(1'b0);
    idle(60);
    check("blk_vec", dut_vec, '0);

    // Opposite corners only
    step(1'b1, 0, 0, 1'b1);
    frame_end(1'b1);
    idle(60);
    check("crn_count", W'(oCount), W'(2));
    check("crn_box", W'({oX_Min, oX_Max, oY_Min, oY_Max}), W'({16'd0, 16'd639, 16'd0, 16'd479}));
    check("crn_cent", W'({oCent_X, oCent_Y}), W'({16'd319, 16'd239}));

    // Second frame end 10 cycles after the first is dropped
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 10, 20, 1'b1);
    step(1'b1, 30, 40, 1'b1);
    step(1'b1, 50, 60, 1'b1);
    frame_end(1'b0);
    idle(9);
    frame_end(1'b1);
    idle(60);
    check("drop_count", W'(oCount), W'(3));
    check("drop_box", W'({oX_Min, oX_Max, oY_Min, oY_Max}), W'({16'd10, 16'd50, 16'd20, 16'd60}));
    check("drop_cent", W'({oCent_X, oCent_Y}), W'({16'd30, 16'd40}));

    // One pixel below the minimum count
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 200, 100, 1'b1);
    frame_end(1'b0);
    idle(60);
    check("low_vec", dut_vec, W'({20'd1, 1'b0, 96'd0}));

    // Reset during DIV_Y, then a full frame
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 300, 200, 1'b1);
    step(1'b1, 310, 210, 1'b1);
    frame_end(1'b0);
    idle(40);
    do_reset();
    idle(70);
    step(1'b1, 0, 0, 1'b0);
    step(1'b1, 5, 7, 1'b1);
    step(1'b1, 9, 11, 1'b1);
    step(1'b1, 13, 2, 1'b1);
    frame_end(1'b0);
    idle(60);
    check("rst_count", W'(oCount), W'(3));
    check("rst_cent", W'({oCent_X, oCent_Y}), W'({16'd9, 16'd6}));

    // Random sparse frames, some without frame start, some with short gaps
    for (int f = 0; f < 12; f++) begin
      int n;
      if ($urandom_range(0, 3) != 0) step(1'b1, 0, 0, 1'($urandom_range(0, 1)));
      n = $urandom_range(1, 60);
      for (int i = 0; i < n; i++)
        step(1'($urandom_range(0, 7) != 0), $urandom_range(0, 700), $urandom_range(0, 520),
             1'($urandom_range(0, 1)));
      frame_end(1'($urandom_range(0, 1)));
      idle($urandom_range(0, 80));
    end
    idle(62);
    check("pending", W'(due_q.size()), W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
